// File: rtl/pipeexe_mdu_if.sv
// Execute-stage bundle between ID/EXE, EXE/MEM and the hazard unit.
// master drives the decoded instruction; slave is the execute stage.
interface pipeexe_mdu_if #(
    parameter int WIDTH = 32,
    parameter int RN_W  = 5
);
    logic [3:0]       ealuc;
    logic             ealuimm;
    logic             eshift;
    logic             ejal;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic [WIDTH-1:0] eimm;
    logic [WIDTH-1:0] epc4;
    logic [RN_W-1:0]  ern0;
    logic [1:0]       emdop;
    logic [RN_W-1:0]  ern;
    logic [WIDTH-1:0] ealu;
    logic             estall;
    logic             emd_valid;

    modport master (
        output ealuc, ealuimm, eshift, ejal,
        output ea, eb, eimm, epc4, ern0, emdop,
        input  ern, ealu, estall, emd_valid
    );

    modport slave (
        input  ealuc, ealuimm, eshift, ejal,
        input  ea, eb, eimm, epc4, ern0, emdop,
        output ern, ealu, estall, emd_valid
    );
endinterface

// File: rtl/pipeexe_mdu.sv
// Execute stage: combinational ALU / jal link plus iterative mul/div.
// Define PIPEEXE_SIGNED_MD_EN for two's-complement mul/div operands.
module pipeexe_mdu #(
    parameter int WIDTH       = 32,
    parameter int RN_W        = 5,
    parameter int LINK_OFFSET = 4
) (
    input  logic          clock,
    input  logic          reset,
    pipeexe_mdu_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] opa, opb, ma, mb;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res, link, raw, md_res;
    logic [WIDTH:0]   tmp, dif;
    logic             neg;

    assign opa   = bus.eshift  ? bus.eimm : bus.ea;
    assign opb   = bus.ealuimm ? bus.eimm : bus.eb;
    assign shamt = opa[SW-1:0];
    assign link  = bus.epc4 + WIDTH'(LINK_OFFSET);

`ifdef PIPEEXE_SIGNED_MD_EN
    logic sa_q, sa_d, sb_q, sb_d;

    assign ma  = opa[WIDTH-1] ? -opa : opa;
    assign mb  = opb[WIDTH-1] ? -opb : opb;
    assign neg = !dz_q && ((op_q == 2'b11) ? sa_q : (sa_q ^ sb_q));
`else
    assign ma  = opa;
    assign mb  = opb;
    assign neg = 1'b0;
`endif

    assign raw    = (op_q == 2'b10) ? x_q : r_q;
    assign md_res = neg ? -raw : raw;

    // Combinational ALU selected by ealuc
    always_comb begin
        alu_res = '0;
        case (bus.ealuc[2:0])
            3'b000: alu_res = opa + opb;
            3'b100: alu_res = opa - opb;
            3'b001: alu_res = opa & opb;
            3'b101: alu_res = opa | opb;
            3'b010: alu_res = opa ^ opb;
            3'b110: alu_res = opb << 16;
            3'b011: alu_res = opb << shamt;
            3'b111: begin
                if (bus.ealuc[3])
                    alu_res = WIDTH'($signed(opb) >>> shamt);
                else
                    alu_res = opb >> shamt;
            end
            default: alu_res = '0;
        endcase
    end

    // MDU next state, datapath step and stage outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        x_d           = x_q;
        y_d           = y_q;
        r_d           = r_q;
        dz_d          = dz_q;
`ifdef PIPEEXE_SIGNED_MD_EN
        sa_d          = sa_q;
        sb_d          = sb_q;
`endif
        tmp           = {r_q, x_q[WIDTH-1]};
        dif           = tmp - {1'b0, y_q};
        bus.estall    = 1'b0;
        bus.emd_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.emdop != 2'b00) begin
                    bus.estall = 1'b1;
                    op_d       = bus.emdop;
`ifdef PIPEEXE_SIGNED_MD_EN
                    sa_d       = opa[WIDTH-1];
                    sb_d       = opb[WIDTH-1];
`endif
                    if (bus.emdop[1] && (opb == '0)) begin
                        // Divide by zero: fixed result, no iteration
                        dz_d    = 1'b1;
                        x_d     = '1;
                        y_d     = '0;
                        r_d     = opa;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        dz_d    = 1'b0;
                        x_d     = ma;
                        y_d     = mb;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                bus.estall = 1'b1;
                cnt_d      = cnt_q - CW'(1);
                if (!op_q[1]) begin
                    if (y_q[0])
                        r_d = r_q + x_q;
                    x_d = x_q << 1;
                    y_d = y_q >> 1;
                end else begin
                    if (tmp >= {1'b0, y_q}) begin
                        r_d = dif[WIDTH-1:0];
                        x_d = {x_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_d = tmp[WIDTH-1:0];
                        x_d = {x_q[WIDTH-2:0], 1'b0};
                    end
                end
                if (cnt_q == CW'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                bus.emd_valid = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // MDU state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
`ifdef PIPEEXE_SIGNED_MD_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
`ifdef PIPEEXE_SIGNED_MD_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
`endif
        end
    end

    // Result select: link beats a finished mul/div, which beats the ALU
    always_comb begin
        bus.ern = bus.ejal ? {RN_W{1'b1}} : bus.ern0;
        if (bus.ejal)
            bus.ealu = link;
        else if (state_q == S_DONE)
            bus.ealu = md_res;
        else
            bus.ealu = alu_res;
    end
endmodule

// File: tb/tb_pipeexe_mdu.sv
// Directed testbench for pipeexe_mdu.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_pipeexe_mdu;
    localparam int W  = 32;
    localparam int RN = 5;

    logic clock = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    pipeexe_mdu_if #(.WIDTH(W), .RN_W(RN)) bus ();

    pipeexe_mdu #(
        .WIDTH(W),
        .RN_W(RN),
        .LINK_OFFSET(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic im, input logic sh,
                         input logic jal, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] i,
                         input logic [W-1:0] pc, input logic [RN-1:0] rn,
                         input logic [1:0] md);
        bus.ealuc   = c;
        bus.ealuimm = im;
        bus.eshift  = sh;
        bus.ejal    = jal;
        bus.ea      = a;
        bus.eb      = b;
        bus.eimm    = i;
        bus.epc4    = pc;
        bus.ern0    = rn;
        bus.emdop   = md;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        tick();
        tick();
        @(negedge clock);
        n_chk++;
        if (bus.estall !== 1'b0 || bus.emd_valid !== 1'b0 || bus.ealu !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: stall=%b valid=%b ealu=%h, want 0 0 0",
                     bus.estall, bus.emd_valid, bus.ealu);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        logic [3:0]  c  [12] = '{4'b0100, 4'b0000, 4'b0001, 4'b0101, 4'b0010, 4'b0110,
                                 4'b0011, 4'b0111, 4'b1111, 4'b0100, 4'b0000, 4'b0011};
        logic        im [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        logic        sh [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
        logic [31:0] a  [12] = '{7, 7, 32'hF0F0, 32'hF0F0, 32'hF0F0, 0,
                                 0, 0, 0, 0, 32'hFFFFFFFF, 0};
        logic [31:0] b  [12] = '{5, 5, 32'hFF00, 32'hFF00, 32'hFF00, 0,
                                 1, 32'h80000000, 32'h80000000, 1, 0, 1};
        logic [31:0] i  [12] = '{0, 0, 0, 0, 0, 32'h1234, 4, 4, 4, 0, 2, 32'h24};
        logic [31:0] e  [12] = '{2, 12, 32'hF000, 32'hFFF0, 32'h0FF0, 32'h12340000,
                                 32'h10, 32'h08000000, 32'hF8000000, 32'hFFFFFFFF,
                                 1, 32'h10};
        for (int k = 0; k < 12; k++) begin
            drive(c[k], im[k], sh[k], 0, a[k], b[k], i[k], 0, 5'd3, 2'b00);
            @(negedge clock);
            n_chk++;
            if (bus.ealu !== e[k] || bus.estall !== 1'b0 || bus.ern !== 5'd3) begin
                n_fail++;
                $display("FAIL alu[%0d]: ealu=%h stall=%b ern=%0d, want %h 0 3",
                         k, bus.ealu, bus.estall, bus.ern, e[k]);
            end
            tick();
        end
    endtask

    task automatic test_jal();
        drive(4'b0100, 0, 0, 1, 7, 5, 0, 32'h100, 5'd3, 2'b00);
        @(negedge clock);
        n_chk++;
        if (bus.ealu !== 32'h104 || bus.ern !== 5'd31) begin
            n_fail++;
            $display("FAIL jal: ealu=%h ern=%0d, want 104 31", bus.ealu, bus.ern);
        end
        tick();
        drive(4'b0100, 0, 0, 1, 7, 5, 0, 32'hFFFFFFFE, 5'd3, 2'b00);
        @(negedge clock);
        n_chk++;
        if (bus.ealu !== 32'h2) begin
            n_fail++;
            $display("FAIL jal_wrap: ealu=%h, want 00000002", bus.ealu);
        end
        tick();
    endtask

    task automatic test_mul();
        logic ok = 1'b1;
        drive(4'b0000, 0, 0, 0, 6, 7, 0, 0, 5'd7, 2'b01);
        for (int cy = 0; cy <= W; cy++) begin
            @(negedge clock);
            if (bus.estall !== 1'b1 || bus.emd_valid !== 1'b0)
                ok = 1'b0;
            tick();
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mul_stall: stall/valid wrong in cycles 0..32, want 1/0");
        end
        @(negedge clock);
        n_chk++;
        if (bus.emd_valid !== 1'b1 || bus.ealu !== 32'd42 ||
            bus.estall !== 1'b0 || bus.ern !== 5'd7) begin
            n_fail++;
            $display("FAIL mul_done: valid=%b ealu=%h stall=%b ern=%0d, want 1 2a 0 7",
                     bus.emd_valid, bus.ealu, bus.estall, bus.ern);
        end
        tick();
        bus.emdop = 2'b00;
        @(negedge clock);
        n_chk++;
        if (bus.estall !== 1'b0 || bus.emd_valid !== 1'b0 || bus.ealu !== 32'd13) begin
            n_fail++;
            $display("FAIL mul_after: stall=%b valid=%b ealu=%h, want 0 0 d",
                     bus.estall, bus.emd_valid, bus.ealu);
        end
        tick();
    endtask

    task automatic test_div();
`ifdef PIPEEXE_SIGNED_MD_EN
        localparam int N = 3;
        logic [1:0]  op [N] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] a  [N] = '{100, 100, 32'h10000};
        logic [31:0] b  [N] = '{7, 7, 32'h10000};
        logic [31:0] e  [N] = '{14, 2, 0};
`else
        localparam int N = 6;
        logic [1:0]  op [N] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b10, 2'b11};
        logic [31:0] a  [N] = '{100, 100, 32'h10000, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b  [N] = '{7, 7, 32'h10000, 32'hFFFFFFFF, 16, 16};
        logic [31:0] e  [N] = '{14, 2, 0, 1, 32'h0FFFFFFF, 15};
`endif
        for (int k = 0; k < N; k++) begin
            logic ok = 1'b1;
            drive(4'b0000, 0, 0, 0, a[k], b[k], 0, 0, 5'd9, op[k]);
            for (int cy = 0; cy <= W; cy++) begin
                @(negedge clock);
                if (bus.estall !== 1'b1 || bus.emd_valid !== 1'b0)
                    ok = 1'b0;
                tick();
            end
            @(negedge clock);
            n_chk++;
            if (!ok || bus.emd_valid !== 1'b1 || bus.ealu !== e[k]) begin
                n_fail++;
                $display("FAIL md[%0d]: stall_ok=%b valid=%b ealu=%h, want 1 1 %h",
                         k, ok, bus.emd_valid, bus.ealu, e[k]);
            end
            tick();
        end
        bus.emdop = 2'b00;
        tick();
    endtask

    task automatic test_div_zero();
        logic [1:0]  op [2] = '{2'b10, 2'b11};
        logic [31:0] e  [2] = '{32'hFFFFFFFF, 32'h1234};
        for (int k = 0; k < 2; k++) begin
            drive(4'b0000, 0, 0, 0, 32'h1234, 0, 0, 0, 5'd1, op[k]);
            @(negedge clock);
            n_chk++;
            if (bus.estall !== 1'b1 || bus.emd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL dz_issue[%0d]: stall=%b valid=%b, want 1 0",
                         k, bus.estall, bus.emd_valid);
            end
            tick();
            @(negedge clock);
            n_chk++;
            if (bus.estall !== 1'b0 || bus.emd_valid !== 1'b1 || bus.ealu !== e[k]) begin
                n_fail++;
                $display("FAIL dz_done[%0d]: stall=%b valid=%b ealu=%h, want 0 1 %h",
                         k, bus.estall, bus.emd_valid, bus.ealu, e[k]);
            end
            tick();
        end
        bus.emdop = 2'b00;
        @(negedge clock);
        n_chk++;
        if (bus.estall !== 1'b0 || bus.emd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_after: stall=%b valid=%b, want 0 0",
                     bus.estall, bus.emd_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic ok = 1'b1;
        drive(4'b0000, 0, 0, 0, 3, 5, 0, 0, 5'd2, 2'b01);
        for (int cy = 0; cy <= W; cy++)
            tick();
        @(negedge clock);
        n_chk++;
        if (bus.emd_valid !== 1'b1 || bus.ealu !== 32'd15 || bus.estall !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b ealu=%h stall=%b, want 1 f 0",
                     bus.emd_valid, bus.ealu, bus.estall);
        end
        tick();
        drive(4'b0000, 0, 0, 1, 9, 9, 0, 32'h200, 5'd2, 2'b01);
        @(negedge clock);
        n_chk++;
        if (bus.estall !== 1'b1 || bus.emd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_issue: stall=%b valid=%b, want 1 0",
                     bus.estall, bus.emd_valid);
        end
        tick();
        for (int cy = 1; cy <= W; cy++) begin
            @(negedge clock);
            if (bus.estall !== 1'b1)
                ok = 1'b0;
            tick();
        end
        @(negedge clock);
        n_chk++;
        if (!ok || bus.emd_valid !== 1'b1 || bus.ealu !== 32'h204 || bus.ern !== 5'd31) begin
            n_fail++;
            $display("FAIL b2b_jal_done: stall_ok=%b valid=%b ealu=%h ern=%0d, want 1 1 204 31",
                     ok, bus.emd_valid, bus.ealu, bus.ern);
        end
        tick();
        drive(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        tick();
    endtask

    task automatic test_reset_mid();
        logic ok = 1'b1;
        drive(4'b0000, 0, 0, 0, 6, 7, 0, 0, 5'd4, 2'b01);
        for (int cy = 0; cy < 10; cy++)
            tick();
        reset     = 1'b1;
        bus.emdop = 2'b00;
        @(negedge clock);
        n_chk++;
        if (bus.estall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy: stall=%b, want 1", bus.estall);
        end
        tick();
        reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if (bus.estall !== 1'b0 || bus.emd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: stall=%b valid=%b, want 0 0",
                     bus.estall, bus.emd_valid);
        end
        tick();
        for (int cy = 0; cy < 40; cy++) begin
            @(negedge clock);
            if (bus.estall !== 1'b0 || bus.emd_valid !== 1'b0)
                ok = 1'b0;
            tick();
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: stall or valid rose after abandoned op, want 0");
        end
        bus.emdop = 2'b01;
        @(negedge clock);
        n_chk++;
        if (bus.estall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_follow: stall=%b, want 1", bus.estall);
        end
        reset = 1'b1;
        tick();
        bus.emdop = 2'b00;
        reset     = 1'b0;
        tick();
    endtask

`ifdef PIPEEXE_SIGNED_MD_EN
    task automatic test_signed();
        logic [1:0]  op [7] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
        logic [31:0] a  [7] = '{-32'sd20, -32'sd20, -32'sd4, 32'h80000000,
                                32'h80000000, -32'sd20, -32'sd20};
        logic [31:0] b  [7] = '{3, 3, 5, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0};
        logic [31:0] e  [7] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFEC,
                                32'h80000000, 0, 32'hFFFFFFFF, 32'hFFFFFFEC};
        for (int k = 0; k < 7; k++) begin
            int lim = (b[k] == 0) ? 1 : W + 1;
            drive(4'b0000, 0, 0, 0, a[k], b[k], 0, 0, 5'd5, op[k]);
            for (int cy = 0; cy < lim; cy++)
                tick();
            @(negedge clock);
            n_chk++;
            if (bus.emd_valid !== 1'b1 || bus.ealu !== e[k]) begin
                n_fail++;
                $display("FAIL signed[%0d]: valid=%b ealu=%h, want 1 %h",
                         k, bus.emd_valid, bus.ealu, e[k]);
            end
            tick();
        end
        bus.emdop = 2'b00;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_jal();
        test_mul();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
`ifdef PIPEEXE_SIGNED_MD_EN
        test_signed();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
